// File: rtl/difftest_step_pkg.sv
// Shared types for the difftest step batcher.
// Contents: default step width, batcher state encoding, step count type.
// No ports (package only).
package difftest_step_pkg;

    localparam int DEFAULT_STEP_WIDTH = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } batch_state_e;

    typedef logic [DEFAULT_STEP_WIDTH-1:0] step_t;

endpackage

// File: rtl/difftest_idle_timer.sv
// Saturating count of consecutive idle cycles for the step batcher.
// Ports: clock, reset (sync, active-low), clr (zero the count), inc (count one idle
// cycle), expired (count has reached IDLE_TIMEOUT-1).
module difftest_idle_timer #(
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(IDLE_TIMEOUT - 1);

    logic [CW-1:0] idle;

    always_ff @(posedge clock) begin
        if (!reset) begin
            idle <= '0;
        end else if (clr) begin
            idle <= '0;
        end else if (inc && (idle != LAST)) begin
            idle <= idle + CW'(1);
        end
    end

    assign expired = (idle == LAST);

endmodule

// File: rtl/difftest_step_batcher.sv
// Batches cycles carrying difftest events into one registered difftest_step pulse.
// Ports: clock, reset (sync, active-low), enable, in_valid, in_trap -> difftest_step
// (1-cycle count pulse), done (sticky after trap), total_steps, batch_count.
module difftest_step_batcher
    import difftest_step_pkg::*;
#(
    parameter int STEP_WIDTH   = DEFAULT_STEP_WIDTH,
    parameter int BATCH_SIZE   = 32,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic                  in_trap,
    output logic [STEP_WIDTH-1:0] difftest_step,
    output logic                  done,
    output logic [63:0]           total_steps,
    output logic [31:0]           batch_count
);

    localparam logic [STEP_WIDTH:0] FULL = (STEP_WIDTH + 1)'(BATCH_SIZE);

    batch_state_e          state;
    batch_state_e          state_d;
    logic [STEP_WIDTH-1:0] acc;
    logic [STEP_WIDTH-1:0] acc_d;
    logic [STEP_WIDTH-1:0] step_d;
    logic [STEP_WIDTH:0]   nxt;
    logic                  v;
    logic                  acc_nz;
    logic                  expired;
    logic                  idle_clr;
    logic                  idle_inc;

    difftest_idle_timer #(
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) u_idle_timer (
        .clock   (clock),
        .reset   (reset),
        .clr     (idle_clr),
        .inc     (idle_inc),
        .expired (expired)
    );

    // Flush priority: trap > full > idle timeout. nxt is one bit wider than acc so
    // the compare against BATCH_SIZE cannot alias; every loaded value is at most
    // BATCH_SIZE, which fits STEP_WIDTH, so dropping the top bit is lossless.
    always_comb begin
        v        = in_valid & enable;
        nxt      = {1'b0, acc} + {{STEP_WIDTH{1'b0}}, v};
        acc_nz   = |acc;
        state_d  = state;
        acc_d    = acc;
        step_d   = '0;
        idle_clr = 1'b1;
        idle_inc = 1'b0;

        if (state == ACCUM) begin
            if (in_trap) begin
                step_d  = nxt[STEP_WIDTH-1:0];
                acc_d   = '0;
                state_d = DONE;
            end else if (nxt == FULL) begin
                step_d = nxt[STEP_WIDTH-1:0];
                acc_d  = '0;
            end else if (!v && acc_nz && expired) begin
                // No valid this cycle, so acc is the whole batch.
                step_d = acc;
                acc_d  = '0;
            end else begin
                acc_d    = nxt[STEP_WIDTH-1:0];
                // Idle counting only runs while a nonempty batch waits for input.
                idle_clr = v | ~acc_nz;
                idle_inc = 1'b1;
            end
        end else begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ACCUM;
            acc           <= '0;
            difftest_step <= '0;
            done          <= 1'b0;
            total_steps   <= '0;
            batch_count   <= '0;
        end else begin
            state         <= state_d;
            acc           <= acc_d;
            difftest_step <= step_d;
            // Trails the trap flush by one cycle because it follows the registered state.
            done          <= done | (state == DONE);
            if (step_d != '0) begin
                total_steps <= total_steps + 64'(step_d);
                batch_count <= batch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_difftest_step_batcher.sv
module tb_difftest_step_batcher;
    import difftest_step_pkg::*;

    localparam int BS = 4;
    localparam int IT = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic        in_trap;
    step_t       difftest_step;
    logic        done;
    logic [63:0] total_steps;
    logic [31:0] batch_count;

    int checks   = 0;
    int failures = 0;

    difftest_step_batcher #(
        .STEP_WIDTH   (DEFAULT_STEP_WIDTH),
        .BATCH_SIZE   (BS),
        .IDLE_TIMEOUT (IT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .in_valid      (in_valid),
        .in_trap       (in_trap),
        .difftest_step (difftest_step),
        .done          (done),
        .total_steps   (total_steps),
        .batch_count   (batch_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        enable   = 1'b1;
        in_valid = 1'b0;
        in_trap  = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        enable   = 1'b1;
        in_valid = 1'b1;
        in_trap  = 1'b0;
        tick();
        tick();
        checks++; if (difftest_step !== 8'd0) begin failures++; $display("FAIL reset_step got=%0d exp=0", difftest_step); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (total_steps !== 64'd0) begin failures++; $display("FAIL reset_total got=%0d exp=0", total_steps); end
        checks++; if (batch_count !== 32'd0) begin failures++; $display("FAIL reset_batch got=%0d exp=0", batch_count); end
        reset    = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_full_batch();
        logic [7:0] exp;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            tick();
            exp = (i % BS == 0) ? 8'd4 : 8'd0;
            checks++; if (difftest_step !== exp) begin failures++; $display("FAIL full_step cyc=%0d got=%0d exp=%0d", i, difftest_step, exp); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (difftest_step !== 8'd0) begin failures++; $display("FAIL full_after got=%0d exp=0", difftest_step); end
        checks++; if (total_steps !== 64'd8) begin failures++; $display("FAIL full_total got=%0d exp=8", total_steps); end
        checks++; if (batch_count !== 32'd2) begin failures++; $display("FAIL full_batch got=%0d exp=2", batch_count); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL full_done got=%0b exp=0", done); end
    endtask

    // Runs straight after test_full_batch without reset so the stats keep accumulating.
    task automatic test_idle_timeout();
        logic [7:0] exp;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            tick();
            checks++; if (difftest_step !== 8'd0) begin failures++; $display("FAIL idle_fill cyc=%0d got=%0d exp=0", i, difftest_step); end
        end
        in_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = (k == IT) ? 8'd3 : 8'd0;
            checks++; if (difftest_step !== exp) begin failures++; $display("FAIL idle_step k=%0d got=%0d exp=%0d", k, difftest_step, exp); end
        end
        checks++; if (total_steps !== 64'd11) begin failures++; $display("FAIL idle_total got=%0d exp=11", total_steps); end
        checks++; if (batch_count !== 32'd3) begin failures++; $display("FAIL idle_batch got=%0d exp=3", batch_count); end
    endtask

    task automatic test_trap();
        do_reset();
        in_valid = 1'b1;
        tick();
        tick();
        in_trap = 1'b1;
        tick();
        checks++; if (difftest_step !== 8'd3) begin failures++; $display("FAIL trap_step got=%0d exp=3", difftest_step); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL trap_done_early got=%0b exp=0", done); end
        in_valid = 1'b0;
        in_trap  = 1'b0;
        tick();
        checks++; if (difftest_step !== 8'd0) begin failures++; $display("FAIL trap_next_step got=%0d exp=0", difftest_step); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL trap_done got=%0b exp=1", done); end
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_trap  = (i % 3 == 0);
            tick();
            checks++; if (difftest_step !== 8'd0) begin failures++; $display("FAIL trap_dead_step cyc=%0d got=%0d exp=0", i, difftest_step); end
            checks++; if (done !== 1'b1) begin failures++; $display("FAIL trap_dead_done cyc=%0d got=%0b exp=1", i, done); end
        end
        in_valid = 1'b0;
        in_trap  = 1'b0;
        checks++; if (total_steps !== 64'd3) begin failures++; $display("FAIL trap_total got=%0d exp=3", total_steps); end
        checks++; if (batch_count !== 32'd1) begin failures++; $display("FAIL trap_batch got=%0d exp=1", batch_count); end
    endtask

    task automatic test_trap_empty();
        do_reset();
        in_trap = 1'b1;
        tick();
        checks++; if (difftest_step !== 8'd0) begin failures++; $display("FAIL empty_trap_step got=%0d exp=0", difftest_step); end
        in_trap = 1'b0;
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL empty_trap_done got=%0b exp=1", done); end
        checks++; if (batch_count !== 32'd0) begin failures++; $display("FAIL empty_trap_batch got=%0d exp=0", batch_count); end
        checks++; if (total_steps !== 64'd0) begin failures++; $display("FAIL empty_trap_total got=%0d exp=0", total_steps); end
    endtask

    task automatic test_enable_gate();
        logic [7:0] exp;
        do_reset();
        in_valid = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp = (k == IT) ? 8'd2 : 8'd0;
            checks++; if (difftest_step !== exp) begin failures++; $display("FAIL gate_step k=%0d got=%0d exp=%0d", k, difftest_step, exp); end
        end
        checks++; if (total_steps !== 64'd2) begin failures++; $display("FAIL gate_total got=%0d exp=2", total_steps); end
        checks++; if (batch_count !== 32'd1) begin failures++; $display("FAIL gate_batch got=%0d exp=1", batch_count); end
        enable   = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_batch();
        logic [7:0] exp;
        do_reset();
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        checks++; if (difftest_step !== 8'd0) begin failures++; $display("FAIL mid_rst_step got=%0d exp=0", difftest_step); end
        checks++; if (total_steps !== 64'd0) begin failures++; $display("FAIL mid_rst_total got=%0d exp=0", total_steps); end
        checks++; if (batch_count !== 32'd0) begin failures++; $display("FAIL mid_rst_batch got=%0d exp=0", batch_count); end
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (difftest_step !== 8'd0) begin failures++; $display("FAIL mid_rst_idle k=%0d got=%0d exp=0", k, difftest_step); end
        end
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            tick();
            exp = (i == 4) ? 8'd4 : 8'd0;
            checks++; if (difftest_step !== exp) begin failures++; $display("FAIL mid_rst_refill cyc=%0d got=%0d exp=%0d", i, difftest_step, exp); end
        end
        in_valid = 1'b0;
        checks++; if (total_steps !== 64'd4) begin failures++; $display("FAIL mid_rst_total2 got=%0d exp=4", total_steps); end
        checks++; if (batch_count !== 32'd1) begin failures++; $display("FAIL mid_rst_batch2 got=%0d exp=1", batch_count); end
    endtask

    // Trap coincident with the valid that would fill the batch: one pulse of BATCH_SIZE.
    task automatic test_trap_at_full();
        do_reset();
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        in_trap = 1'b1;
        tick();
        checks++; if (difftest_step !== 8'd4) begin failures++; $display("FAIL trapfull_step got=%0d exp=4", difftest_step); end
        in_valid = 1'b0;
        in_trap  = 1'b0;
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL trapfull_done got=%0b exp=1", done); end
        checks++; if (batch_count !== 32'd1) begin failures++; $display("FAIL trapfull_batch got=%0d exp=1", batch_count); end
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b1;
        in_valid = 1'b0;
        in_trap  = 1'b0;
        test_reset();
        test_full_batch();
        test_idle_timeout();
        test_trap();
        test_trap_empty();
        test_enable_gate();
        test_reset_mid_batch();
        test_trap_at_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
